// File: rtl/order_manager_pkg.sv
// Shared order_manager definitions: FSM state encodings, order side constants,
// and the saturating drop-counter limit with its increment helper.
package order_manager_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SEND = 2'd1,
      ST_COOL = 2'd2
   } state_t;

   localparam logic        SIDE_BUY  = 1'b1;
   localparam logic        SIDE_SELL = 1'b0;
   localparam logic [15:0] DROP_SAT  = 16'hFFFF;

   function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
      return (inc && (v != DROP_SAT)) ? v + 16'd1 : v;
   endfunction

endpackage

// File: rtl/order_manager_cooldown_timer.sv
// Loadable down-counter, count visible the cycle after load; done_o while it reads 1.
// No backpressure: load_i has priority over dec_i, and the count holds at 0.
module cooldown_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/order_manager.sv
// Turns algo buy/sell ticks into single-qty orders under a position limit and post-fill cooldown.
// Order valid one cycle after accept, held until ord_ready; ORDER_MGR_STALE_EN adds a withdrawal timeout.
module order_manager
   import order_manager_pkg::*;
#(
   parameter int PRICE_W   = 32,
   parameter int QTY_W     = 16,
   parameter int ORDER_QTY = 1,
   parameter int POS_LIMIT = 8,
   parameter int COOLDOWN  = 4,
   parameter int STALE_CYC = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sig_valid,
   input  logic               buy_sig,
   input  logic               sell_sig,
   input  logic [PRICE_W-1:0] time_,
   input  logic [PRICE_W-1:0] price_,
   output logic               ord_valid,
   input  logic               ord_ready,
   output logic               ord_side,
   output logic [PRICE_W-1:0] ord_price,
   output logic [PRICE_W-1:0] ord_time,
   output logic [QTY_W-1:0]   ord_qty,
   output logic [QTY_W-1:0]   position,
   output logic [15:0]        drop_cnt,
   output logic               busy
);

   localparam logic signed [QTY_W:0] QTY_X   = (QTY_W+1)'(ORDER_QTY);
   localparam logic signed [QTY_W:0] LIM_X   = (QTY_W+1)'(POS_LIMIT);
   localparam logic [QTY_W-1:0]      QTY_LD  = QTY_W'(ORDER_QTY);
   localparam logic [15:0]           COOL_LD = 16'(COOLDOWN);

   state_t                    state_q, state_d;
   logic                      side_q, side_d;
   logic [PRICE_W-1:0]        price_q, price_d;
   logic [PRICE_W-1:0]        time_q, time_d;
   logic signed [QTY_W-1:0]   pos_q, pos_d;
   logic [15:0]               drop_q, drop_d;
   logic                      drop_evt, accept, cool_load, cool_done, sig_nz;
   logic signed [QTY_W:0]     pos_ext, pos_up, pos_dn;

   // One extra bit of headroom so the limit compares can never wrap.
   assign pos_ext = {pos_q[QTY_W-1], pos_q};
   assign pos_up  = pos_ext + QTY_X;
   assign pos_dn  = pos_ext - QTY_X;
   assign sig_nz  = sig_valid && (buy_sig || sell_sig);

`ifdef ORDER_MGR_STALE_EN
   logic stale_done;

   cooldown_timer #(.W(16)) u_stale (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (accept),
      .load_val_i(16'(STALE_CYC)),
      .dec_i     (state_q == ST_SEND),
      .done_o    (stale_done)
   );
`endif

   cooldown_timer #(.W(16)) u_cool (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (cool_load),
      .load_val_i(COOL_LD),
      .dec_i     (state_q == ST_COOL),
      .done_o    (cool_done)
   );

   always_comb begin
      state_d   = state_q;
      side_d    = side_q;
      price_d   = price_q;
      time_d    = time_q;
      pos_d     = pos_q;
      drop_evt  = 1'b0;
      accept    = 1'b0;
      cool_load = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sig_valid) begin
               if (buy_sig && sell_sig) begin
                  drop_evt = 1'b1;
               end else if (buy_sig) begin
                  if (pos_up <= LIM_X) begin
                     accept = 1'b1;
                     side_d = SIDE_BUY;
                  end else begin
                     drop_evt = 1'b1;
                  end
               end else if (sell_sig) begin
                  if (pos_dn >= -LIM_X) begin
                     accept = 1'b1;
                     side_d = SIDE_SELL;
                  end else begin
                     drop_evt = 1'b1;
                  end
               end
            end
            if (accept) begin
               price_d = price_;
               time_d  = time_;
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            drop_evt = sig_nz;
            if (ord_ready) begin
               pos_d = (side_q == SIDE_BUY) ? pos_up[QTY_W-1:0] : pos_dn[QTY_W-1:0];
               if (COOLDOWN == 0) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_COOL;
                  cool_load = 1'b1;
               end
            end
`ifdef ORDER_MGR_STALE_EN
            else if (stale_done) begin
               state_d  = ST_IDLE;
               drop_evt = 1'b1;
            end
`endif
         end
         ST_COOL: begin
            drop_evt = sig_nz;
            if (cool_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      drop_d = sat_inc(drop_q, drop_evt);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         side_q  <= 1'b0;
         price_q <= '0;
         time_q  <= '0;
         pos_q   <= '0;
         drop_q  <= '0;
      end else begin
         state_q <= state_d;
         side_q  <= side_d;
         price_q <= price_d;
         time_q  <= time_d;
         pos_q   <= pos_d;
         drop_q  <= drop_d;
      end
   end

   assign ord_valid = (state_q == ST_SEND);
   assign ord_side  = side_q;
   assign ord_price = price_q;
   assign ord_time  = time_q;
   assign ord_qty   = (state_q == ST_SEND) ? QTY_LD : '0;
   assign position  = pos_q;
   assign drop_cnt  = drop_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_order_manager.sv
// Self-checking bench for order_manager: directed scenarios plus randomized ticks
// checked against a cycle-level behavioural model of the order flow.
module tb_order_manager;

   localparam int PRICE_W   = 32;
   localparam int QTY_W     = 16;
   localparam int ORDER_QTY = 1;
   localparam int POS_LIMIT = 8;
   localparam int COOLDOWN  = 4;
   localparam int STALE_CYC = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        sig_valid = 1'b0, buy_sig = 1'b0, sell_sig = 1'b0, ord_ready = 1'b0;
   logic [31:0] time_ = '0, price_ = '0;
   logic        ord_valid, ord_side, busy;
   logic [31:0] ord_price, ord_time;
   logic [15:0] ord_qty, position, drop_cnt;

   int checks = 0;
   int failures = 0;

   // Behavioural model: an order is either pending or not; accepts are allowed
   // from edge m_free onward, which a fill pushes to fill_edge+1+COOLDOWN.
   int          m_pos, m_drops, m_edge, m_free, m_age;
   bit          m_pend, m_side;
   logic [31:0] m_price, m_time;

   order_manager #(
      .PRICE_W(PRICE_W), .QTY_W(QTY_W), .ORDER_QTY(ORDER_QTY),
      .POS_LIMIT(POS_LIMIT), .COOLDOWN(COOLDOWN), .STALE_CYC(STALE_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sig_valid(sig_valid), .buy_sig(buy_sig),
      .sell_sig(sell_sig), .time_(time_), .price_(price_), .ord_valid(ord_valid),
      .ord_ready(ord_ready), .ord_side(ord_side), .ord_price(ord_price),
      .ord_time(ord_time), .ord_qty(ord_qty), .position(position),
      .drop_cnt(drop_cnt), .busy(busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      m_pos = 0; m_drops = 0; m_edge = 0; m_free = 0; m_age = 0;
      m_pend = 0; m_side = 0; m_price = '0; m_time = '0;
   endfunction

   function automatic void model_edge();
      bit nz   = sig_valid && (buy_sig || sell_sig);
      bit drop = 0;
      bit acc  = 0;
      m_edge++;
      if (m_pend) begin
         drop = nz;
         if (ord_ready) begin
            m_pend = 0;
            m_pos  = m_side ? m_pos + ORDER_QTY : m_pos - ORDER_QTY;
            m_free = m_edge + 1 + COOLDOWN;
         end
`ifdef ORDER_MGR_STALE_EN
         else begin
            m_age++;
            if (m_age == STALE_CYC) begin
               m_pend = 0; drop = 1; m_free = m_edge + 1;
            end
         end
`endif
      end else if (m_edge < m_free) begin
         drop = nz;
      end else if (sig_valid) begin
         if (buy_sig && sell_sig) drop = 1;
         else if (buy_sig) begin
            if (m_pos + ORDER_QTY <= POS_LIMIT) begin acc = 1; m_side = 1; end
            else drop = 1;
         end else if (sell_sig) begin
            if (m_pos - ORDER_QTY >= -POS_LIMIT) begin acc = 1; m_side = 0; end
            else drop = 1;
         end
      end
      if (acc) begin
         m_pend = 1; m_price = price_; m_time = time_; m_age = 0;
      end
      if (drop && m_drops < 65535) m_drops++;
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst_n) model_edge();
      #1;
   endtask

   task automatic do_reset();
      sig_valid = 0; buy_sig = 0; sell_sig = 0; ord_ready = 0;
      rst_n = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #3 rst_n = 1;
   endtask

   task automatic test_reset();
      #1 rst_n = 0;
      #1;
      checks++;
      if ({ord_valid, ord_side, ord_price, ord_time, ord_qty, position, drop_cnt, busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b side=%b price=%0d time=%0d qty=%0d pos=%0d drops=%0d busy=%b, want all 0",
                  ord_valid, ord_side, ord_price, ord_time, ord_qty, position, drop_cnt, busy);
      end
      do_reset();
   endtask

   task automatic test_single_buy();
      int n;
      do_reset();
      ord_ready = 1; sig_valid = 1; buy_sig = 1; price_ = 100; time_ = 5;
      tick();
      sig_valid = 0; buy_sig = 0;
      checks++;
      if ({ord_valid, ord_side, ord_price, ord_time, ord_qty} !== {1'b1, 1'b1, 32'd100, 32'd5, 16'd1}) begin
         failures++;
         $display("FAIL single_order: got valid=%b side=%b price=%0d time=%0d qty=%0d, want 1 1 100 5 1",
                  ord_valid, ord_side, ord_price, ord_time, ord_qty);
      end
      tick();
      checks++;
      if (ord_valid !== 1'b0 || position !== 16'd1) begin
         failures++;
         $display("FAIL single_fill: got valid=%b pos=%0d, want 0 1", ord_valid, position);
      end
      n = busy;
      repeat (8) begin tick(); n += busy; end
      checks++;
      if (n != COOLDOWN) begin
         failures++;
         $display("FAIL cooldown_busy: got %0d busy cycles, want %0d", n, COOLDOWN);
      end
   endtask

   task automatic test_pos_limit();
      do_reset();
      ord_ready = 1;
      for (int k = 0; k < 2 * POS_LIMIT + 2; k++) begin
         sig_valid = 1; buy_sig = (k <= POS_LIMIT); sell_sig = (k > POS_LIMIT);
         price_ = $urandom; time_ = k;
         tick();
         sig_valid = 0; buy_sig = 0; sell_sig = 0;
         repeat (7) tick();
         if (k == POS_LIMIT) begin
            checks++;
            if (position !== 16'd8 || drop_cnt !== 16'd1) begin
               failures++;
               $display("FAIL long_limit: got pos=%0d drops=%0d, want 8 1", position, drop_cnt);
            end
         end
      end
      // 9 sells from +8 reach -1; the remaining trips fall far short of the short limit.
      checks++;
      if (position !== 16'hFFFF || drop_cnt !== 16'd1) begin
         failures++;
         $display("FAIL sell_path: got pos=%0d drops=%0d, want -1 1", $signed(position), drop_cnt);
      end
      for (int k = 0; k < POS_LIMIT; k++) begin
         sig_valid = 1; sell_sig = 1; tick();
         sig_valid = 0; sell_sig = 0;
         repeat (7) tick();
      end
      checks++;
      if (position !== 16'hFFF8 || drop_cnt !== 16'd2) begin
         failures++;
         $display("FAIL short_limit: got pos=%0d drops=%0d, want -8 2", $signed(position), drop_cnt);
      end
   endtask

   task automatic test_conflict();
      do_reset();
      ord_ready = 1; sig_valid = 1; buy_sig = 1; sell_sig = 1;
      tick();
      buy_sig = 0; sell_sig = 0;
      tick();
      sig_valid = 0;
      checks++;
      if (ord_valid !== 1'b0 || drop_cnt !== 16'd1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL conflict: got valid=%b drops=%0d busy=%b, want 0 1 0", ord_valid, drop_cnt, busy);
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] p;
      do_reset();
      p = $urandom;
      ord_ready = 0; sig_valid = 1; buy_sig = 1; price_ = p; time_ = 77;
      tick();
      for (int k = 0; k < 10; k++) begin
         {buy_sig, sell_sig} = 2'($urandom_range(1, 3));
         price_ = $urandom; time_ = 100 + k;
         tick();
         checks++;
         if (ord_valid !== 1'b1 || ord_price !== p || ord_time !== 32'd77 || ord_side !== 1'b1) begin
            failures++;
            $display("FAIL bp_stable[%0d]: got valid=%b price=%0d time=%0d side=%b, want 1 %0d 77 1",
                     k, ord_valid, ord_price, ord_time, ord_side, p);
         end
      end
      checks++;
      if (drop_cnt !== 16'd10) begin
         failures++;
         $display("FAIL bp_drops: got %0d, want 10", drop_cnt);
      end
      sig_valid = 0; buy_sig = 0; sell_sig = 0; ord_ready = 1;
      repeat (6) tick();
      checks++;
      if (position !== 16'd1 || ord_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_fill: got pos=%0d valid=%b, want 1 0", position, ord_valid);
      end
   endtask

   task automatic test_reset_mid_send();
      do_reset();
      ord_ready = 0; sig_valid = 1; buy_sig = 1; price_ = 55; time_ = 9;
      tick();
      sig_valid = 0; buy_sig = 0;
      #3 rst_n = 0;
      #1;
      checks++;
      if ({ord_valid, ord_side, ord_price, ord_time, ord_qty, position, drop_cnt, busy} !== '0) begin
         failures++;
         $display("FAIL reset_mid_send: got valid=%b price=%0d pos=%0d busy=%b, want all 0",
                  ord_valid, ord_price, position, busy);
      end
      model_reset();
      #2 rst_n = 1;
      ord_ready = 1;
      repeat (3) tick();
      checks++;
      if (position !== 16'd0 || ord_valid !== 1'b0) begin
         failures++;
         $display("FAIL order_lost: got pos=%0d valid=%b, want 0 0", position, ord_valid);
      end
   endtask

`ifdef ORDER_MGR_STALE_EN
   task automatic test_stale();
      int n = 0;
      do_reset();
      ord_ready = 0; sig_valid = 1; buy_sig = 1;
      tick();
      sig_valid = 0; buy_sig = 0;
      for (int k = 0; k < 40 && ord_valid; k++) begin n++; tick(); end
      checks++;
      if (n != STALE_CYC || drop_cnt !== 16'd1 || position !== 16'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL stale: got valid_cycles=%0d drops=%0d pos=%0d busy=%b, want %0d 1 0 0",
                  n, drop_cnt, position, busy, STALE_CYC);
      end
   endtask
`endif

   task automatic test_random();
      logic [114:0] exp_v, got_v;
      int phase, r;
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         phase     = (i / 400) % 3;
         r         = $urandom_range(0, 99);
         sig_valid = ($urandom_range(0, 3) != 0);
         if (r < 5) {buy_sig, sell_sig} = 2'b11;
         else if (r < 15) {buy_sig, sell_sig} = 2'b00;
         else if (phase == 0) {buy_sig, sell_sig} = (r < 85) ? 2'b10 : 2'b01;
         else if (phase == 1) {buy_sig, sell_sig} = (r < 85) ? 2'b01 : 2'b10;
         else {buy_sig, sell_sig} = (r < 55) ? 2'b10 : 2'b01;
         price_    = $urandom;
         time_     = i;
         ord_ready = ($urandom_range(0, 3) != 0);
         tick();
         exp_v = {m_pend, m_side, m_price, m_time, (m_pend ? 16'(ORDER_QTY) : 16'd0),
                  16'(m_pos), 16'(m_drops), (m_pend || (m_edge + 1 < m_free))};
         got_v = {ord_valid, ord_side, ord_price, ord_time, ord_qty, position, drop_cnt, busy};
         checks++;
         if (got_v !== exp_v) begin
            failures++;
            $display("FAIL random[%0d]: got %h, want %h", i, got_v, exp_v);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_buy();
      test_pos_limit();
      test_conflict();
      test_backpressure();
      test_reset_mid_send();
`ifdef ORDER_MGR_STALE_EN
      test_stale();
`endif
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
